// File: rtl/spart_pkg.sv
// Shared constants for the SPART processor bus interface: register addresses
// and status-register bit positions.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int STAT_TBR      = 0;
  localparam int STAT_RDA      = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_TX_OVF   = 4;
  localparam int STAT_RX_OVR   = 5;
  localparam int STAT_LOOPBACK = 7;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO with show-ahead head. A push while full is accepted only
// if a pop happens in the same cycle; a pop while empty is ignored.
module spart_sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spart_bus_if.sv
// CPU register interface for the mini SPART: RX/TX FIFOs, sticky error flags
// and baud divisor. Define SPART_LOOPBACK_EN to build TX->RX loopback mode.
module spart_bus_if
  import spart_pkg::*;
#(
  parameter int                  DATA_W     = 8,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [2*DATA_W-1:0] DIV_RESET  = 16'h0145
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iocs,
  input  logic                iorw,
  input  logic [1:0]          ioaddr,
  input  logic [DATA_W-1:0]   databus_in,
  output logic [DATA_W-1:0]   databus_out,
  output logic                databus_oe,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                rda,
  output logic                tbr,
  output logic [2*DATA_W-1:0] brg_div,
  output logic                brg_load
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              rd_acc, wr_acc, wr_status;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0]     rx_count, tx_count;
  logic [DATA_W-1:0] rx_din, rx_head;
  logic              tx_ovf, rx_ovr, loopback, lb_xfer;
  logic [DATA_W-1:0] status;

  assign rd_acc     = iocs & iorw;
  assign wr_acc     = iocs & ~iorw;
  assign wr_status  = wr_acc & (ioaddr == ADDR_STATUS);
  assign databus_oe = rd_acc;

`ifdef SPART_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (rst)            loopback <= 1'b0;
    else if (wr_status) loopback <= databus_in[STAT_LOOPBACK];
  end
  // Loopback only moves a character when RX has room, so it never overruns.
  assign lb_xfer = loopback & ~tx_empty & ~rx_full;
`else
  assign loopback = 1'b0;
  assign lb_xfer  = 1'b0;
`endif

  assign tx_valid = ~tx_empty & ~loopback;
  assign tx_pop   = (tx_valid & tx_ready) | lb_xfer;
  assign tx_push  = wr_acc & (ioaddr == ADDR_DATA);
  assign rx_pop   = rd_acc & (ioaddr == ADDR_DATA) & ~rx_empty;
  assign rx_push  = loopback ? lb_xfer : rx_valid;
  assign rx_din   = loopback ? tx_data : rx_data;
  assign rda      = (rx_count != '0);
  assign tbr      = (tx_count != CW'(FIFO_DEPTH));

  spart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_din),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
  );

  spart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(databus_in),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_data)
  );

  // A new error in the same cycle as a write-1-to-clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      tx_ovf <= (tx_push & tx_full & ~tx_pop) |
                (tx_ovf & ~(wr_status & databus_in[STAT_TX_OVF]));
      rx_ovr <= (rx_push & rx_full & ~rx_pop) |
                (rx_ovr & ~(wr_status & databus_in[STAT_RX_OVR]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brg_div  <= DIV_RESET;
      brg_load <= 1'b0;
    end else begin
      brg_load <= wr_acc & (ioaddr == ADDR_DIV_HI);
      if (wr_acc && ioaddr == ADDR_DIV_LO) brg_div[DATA_W-1:0]        <= databus_in;
      if (wr_acc && ioaddr == ADDR_DIV_HI) brg_div[2*DATA_W-1:DATA_W] <= databus_in;
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_TBR]      = tbr;
    status[STAT_RDA]      = rda;
    status[STAT_TX_EMPTY] = tx_empty;
    status[STAT_RX_FULL]  = rx_full;
    status[STAT_TX_OVF]   = tx_ovf;
    status[STAT_RX_OVR]   = rx_ovr;
    status[STAT_LOOPBACK] = loopback;
  end

  always_comb begin
    databus_out = '0;
    if (rd_acc) begin
      case (ioaddr)
        ADDR_DATA:   databus_out = rx_empty ? '0 : rx_head;
        ADDR_STATUS: databus_out = status;
        ADDR_DIV_LO: databus_out = brg_div[DATA_W-1:0];
        ADDR_DIV_HI: databus_out = brg_div[2*DATA_W-1:DATA_W];
        default:     databus_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_bus_if.sv
// Bench for spart_bus_if: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spart_bus_if;

  logic        clk = 1'b0;
  logic        rst, iocs, iorw, rx_valid, tx_ready;
  logic [1:0]  ioaddr;
  logic [7:0]  databus_in, rx_data;
  logic [7:0]  databus_out, tx_data;
  logic        databus_oe, tx_valid, rda, tbr, brg_load;
  logic [15:0] brg_div;

  always #5 clk = ~clk;

  spart_bus_if dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus_in(databus_in), .databus_out(databus_out), .databus_oe(databus_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rda(rda), .tbr(tbr), .brg_div(brg_div), .brg_load(brg_load)
  );

`ifdef SPART_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: character queues plus flags, advanced once per clock edge.
  logic [7:0]  mrx[$];
  logic [7:0]  mtx[$];
  bit          m_ovf, m_ovr, m_lb, m_load;
  logic [15:0] m_div;

  function automatic logic [7:0] m_status();
    return {m_lb, 1'b0, m_ovr, m_ovf, mrx.size() == 4, mtx.size() == 0,
            mrx.size() != 0, mtx.size() != 4};
  endfunction

  function automatic logic [7:0] m_rdata();
    if (!(iocs && iorw)) return 8'h00;
    case (ioaddr)
      2'd0:    return (mrx.size() > 0) ? mrx[0] : 8'h00;
      2'd1:    return m_status();
      2'd2:    return m_div[7:0];
      default: return m_div[15:8];
    endcase
  endfunction

  task automatic model_step();
    bit rd, wr, rxpop, txpop, lbx, set_ovf, set_ovr;
    int rxn, txn;
    logic [7:0] lbv;
    if (rst) begin
      mrx.delete(); mtx.delete();
      m_ovf = 0; m_ovr = 0; m_lb = 0; m_load = 0; m_div = 16'h0145;
      return;
    end
    rd = iocs && iorw; wr = iocs && !iorw;
    rxn = mrx.size(); txn = mtx.size();
    set_ovf = 0; set_ovr = 0; lbv = 8'h00;
    rxpop = rd && ioaddr == 2'd0 && rxn > 0;
    lbx   = m_lb && txn > 0 && rxn < 4;
    txpop = lbx || (!m_lb && txn > 0 && tx_ready);
    if (txpop) lbv = mtx.pop_front();
    if (wr && ioaddr == 2'd0) begin
      if (txn < 4 || txpop) mtx.push_back(databus_in);
      else set_ovf = 1;
    end
    if (rxpop) void'(mrx.pop_front());
    if (lbx) mrx.push_back(lbv);
    else if (!m_lb && rx_valid) begin
      if (rxn < 4 || rxpop) mrx.push_back(rx_data);
      else set_ovr = 1;
    end
    if (wr && ioaddr == 2'd1) begin
      if (databus_in[4]) m_ovf = 0;
      if (databus_in[5]) m_ovr = 0;
      if (LB) m_lb = databus_in[7];
    end
    if (set_ovf) m_ovf = 1;
    if (set_ovr) m_ovr = 1;
    if (wr && ioaddr == 2'd2) m_div[7:0]  = databus_in;
    if (wr && ioaddr == 2'd3) m_div[15:8] = databus_in;
    m_load = wr && ioaddr == 2'd3;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_oe",    databus_oe, iocs && iorw);
      check("cyc_rdata", databus_out, m_rdata());
      check("cyc_txv",   tx_valid, !m_lb && mtx.size() > 0);
      if (!m_lb && mtx.size() > 0) check("cyc_txd", tx_data, mtx[0]);
      check("cyc_rda",   rda, mrx.size() != 0);
      check("cyc_tbr",   tbr, mtx.size() != 4);
      check("cyc_div",   brg_div, m_div);
      check("cyc_load",  brg_load, m_load);
    end
  end

  task automatic idle();
    iocs = 0; iorw = 0; ioaddr = 0; databus_in = 0; rx_valid = 0; rx_data = 0;
  endtask

  task automatic step(input logic cs, rw, input logic [1:0] a, input logic [7:0] d,
                      input logic rxv, input logic [7:0] rxd, output logic [7:0] q);
    iocs = cs; iorw = rw; ioaddr = a; databus_in = d; rx_valid = rxv; rx_data = rxd;
    @(negedge clk);
    q = databus_out;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    step(1, 0, a, d, 0, 0, q);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] q);
    step(1, 1, a, 0, 0, 0, q);
  endtask

  task automatic rxp(input logic [7:0] d);
    logic [7:0] q;
    step(0, 0, 0, 0, 1, d, q);
  endtask

  initial begin
    logic [7:0] q;
    logic [7:0] got[$];
    rst = 1; tx_ready = 0; idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 0; chk_en = 1;

    rd(2'd1, q);
    check("rst_status", q, 8'h05);
    check("rst_div", brg_div, 16'h0145);
    check("rst_txv", tx_valid, 0);
    check("rst_load", brg_load, 0);

    for (int i = 0; i < 4; i++) wr(2'd0, 8'hA1 + 8'(i));
    check("tx_full_tbr", tbr, 0);
    wr(2'd0, 8'hA5);
    rd(2'd1, q);
    check("tx_ovf_status", q, 8'h10);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (tx_valid) got.push_back(tx_data);
      @(posedge clk); #1;
    end
    check("tx_drain_n", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("tx_drain_d", got[i], 8'hA1 + 8'(i));
    check("tx_drain_end", tx_valid, 0);

    wr(2'd1, 8'h10);
    rd(2'd1, q);
    check("ovf_clear", q, 8'h05);

    for (int i = 0; i < 5; i++) rxp(8'hB0 + 8'(i));
    check("rx_rda", rda, 1);
    rd(2'd1, q);
    check("rx_ovr_status", q, 8'h2F);
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, q);
      check("rx_read", q, 8'hB0 + 8'(i));
    end
    rd(2'd0, q);
    check("rx_empty_read", q, 8'h00);
    check("rx_empty_rda", rda, 0);
    wr(2'd1, 8'h20);
    rd(2'd1, q);
    check("ovr_clear", q, 8'h05);

    for (int i = 0; i < 4; i++) rxp(8'hC0 + 8'(i));
    step(1, 1, 2'd0, 0, 1, 8'hC4, q);
    check("rx_pushpop_q", q, 8'hC0);
    rd(2'd1, q);
    check("rx_pushpop_st", q, 8'h0F);
    for (int i = 1; i < 5; i++) begin
      rd(2'd0, q);
      check("rx_pp_drain", q, 8'hC0 + 8'(i));
    end

    wr(2'd2, 8'h34);
    check("div_lo_noload", brg_load, 0);
    wr(2'd3, 8'h12);
    check("div_val", brg_div, 16'h1234);
    check("div_load1", brg_load, 1);
    @(posedge clk); #1;
    check("div_load0", brg_load, 0);
    rd(2'd3, q);
    check("div_hi_rd", q, 8'h12);

`ifdef SPART_LOOPBACK_EN
    tx_ready = 1;
    wr(2'd1, 8'h80);
    wr(2'd0, 8'h5A);
    check("lb_txv", tx_valid, 0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 2 && !seen; i++) begin
        @(posedge clk); #1;
        check("lb_txv_hold", tx_valid, 0);
        seen = rda;
      end
      check("lb_rda", seen, 1);
    end
    rd(2'd0, q);
    check("lb_data", q, 8'h5A);
    rd(2'd1, q);
    check("lb_status", q, 8'h85);
    wr(2'd1, 8'h00);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      iocs       = $urandom_range(0, 1);
      iorw       = $urandom_range(0, 1);
      ioaddr     = 2'($urandom_range(0, 3));
      databus_in = 8'($urandom);
      rx_valid   = ($urandom_range(0, 2) == 0);
      rx_data    = 8'($urandom);
      tx_ready   = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    rst = 0; idle();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
